// File: rtl/mem_ctrl.sv
// mem_ctrl: shares the single byte-wide RAM port between instruction fetch
// and the MEM stage. Each access is a sequence of byte cycles:
//   loads/fetches: N addresses on consecutive cycles, each byte captured
//                  one cycle later, then a one-cycle done pulse
//   stores:        N write strobes, then a one-cycle mem_done pulse
// Load results are sign- or zero-extended according to the access code.
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   if_req/if_addr         fetch request (held until if_done) and address
//   if_abort               cancels an in-flight fetch (branch redirect)
//   if_done/if_data        fetch completion pulse and instruction word
//   mem_read/mem_write     load code (1 LB,2 LH,3 LW,4 LBU,5 LHU) / store
//                          code (1 SB,2 SH,3 SW), held until mem_done
//   mem_addr/mem_wdata     load/store byte address, store data
//   mem_done/mem_rdata     access completion pulse and extended load data
//   stall_req              combinational: some request still unanswered
//   ram_addr/ram_dout/ram_wr/ram_din   byte RAM port (read data one cycle late)
//
// Build option: define MEM_CTRL_RR_EN for round-robin arbitration between
// IF and MEM on a tie; otherwise MEM always wins.
module mem_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        if_abort,
  output logic        if_done,
  output logic [31:0] if_data,
  input  logic [2:0]  mem_read,
  input  logic [1:0]  mem_write,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic        mem_done,
  output logic [31:0] mem_rdata,
  output logic        stall_req,
  output logic [31:0] ram_addr,
  output logic [7:0]  ram_dout,
  output logic        ram_wr,
  input  logic [7:0]  ram_din
);

  typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, WRITE = 2'd2} state_t;

  state_t      state_reg;
  logic [31:0] base_reg;
  logic [31:0] wdata_reg;
  logic [31:0] buf_reg;
  logic [2:0]  len_reg;
  // step_reg = k means the coming edge is the k-th edge after the grant
  logic [2:0]  step_reg;
  logic        sext_reg;
  logic        owner_if_reg;

`ifdef MEM_CTRL_RR_EN
  logic        last_if_reg;   // 1: IF was the most recent grant
`endif

  logic        mem_rd_valid;
  logic        mem_valid;
  logic        grant_mem;
  logic        grant_if;
  logic [2:0]  mem_len;
  logic        mem_sext;
  logic [1:0]  cap_idx;
  logic [31:0] buf_next;
  logic [31:0] ld_result;

  // Request qualification and arbitration
  always_comb begin
    mem_rd_valid = (mem_read != 3'd0) && (mem_read <= 3'd5);
    mem_valid    = mem_rd_valid || (mem_write != 2'd0);
    stall_req    = (mem_valid && !mem_done) || (if_req && !if_done);
`ifdef MEM_CTRL_RR_EN
    grant_mem    = mem_valid && (!if_req || last_if_reg);
`else
    grant_mem    = mem_valid;
`endif
    grant_if     = if_req && !grant_mem;
  end

  // Byte count and signedness of the MEM access; a store overrides a load
  always_comb begin
    mem_len  = 3'd4;
    mem_sext = 1'b0;
    if (mem_write != 2'd0) begin
      case (mem_write)
        2'd1:    mem_len = 3'd1;
        2'd2:    mem_len = 3'd2;
        default: mem_len = 3'd4;
      endcase
    end else begin
      case (mem_read)
        3'd1:    begin mem_len = 3'd1; mem_sext = 1'b1; end
        3'd2:    begin mem_len = 3'd2; mem_sext = 1'b1; end
        3'd4:    mem_len = 3'd1;
        3'd5:    mem_len = 3'd2;
        default: mem_len = 3'd4;
      endcase
    end
  end

  // Byte arriving on ram_din this cycle belongs to index step-2; merge it so
  // the final byte can be returned at the same edge it is captured.
  always_comb begin
    cap_idx  = step_reg[1:0] - 2'd2;
    buf_next = buf_reg;
    buf_next[{cap_idx, 3'b000} +: 8] = ram_din;
    case (len_reg)
      3'd1:    ld_result = sext_reg ? {{24{buf_next[7]}}, buf_next[7:0]}
                                    : {24'd0, buf_next[7:0]};
      3'd2:    ld_result = sext_reg ? {{16{buf_next[15]}}, buf_next[15:0]}
                                    : {16'd0, buf_next[15:0]};
      default: ld_result = buf_next;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      base_reg     <= 32'd0;
      wdata_reg    <= 32'd0;
      buf_reg      <= 32'd0;
      len_reg      <= 3'd0;
      step_reg     <= 3'd0;
      sext_reg     <= 1'b0;
      owner_if_reg <= 1'b0;
      ram_addr     <= 32'd0;
      ram_dout     <= 8'd0;
      ram_wr       <= 1'b0;
      if_done      <= 1'b0;
      if_data      <= 32'd0;
      mem_done     <= 1'b0;
      mem_rdata    <= 32'd0;
`ifdef MEM_CTRL_RR_EN
      last_if_reg  <= 1'b1;
`endif
    end else begin
      if_done  <= 1'b0;
      mem_done <= 1'b0;
      case (state_reg)
        IDLE: begin
          step_reg <= 3'd1;
          ram_wr   <= 1'b0;
          if (grant_mem) begin
            base_reg     <= mem_addr;
            wdata_reg    <= mem_wdata;
            len_reg      <= mem_len;
            sext_reg     <= mem_sext;
            owner_if_reg <= 1'b0;
            ram_addr     <= mem_addr;
            if (mem_write != 2'd0) begin
              state_reg <= WRITE;
              ram_wr    <= 1'b1;
              ram_dout  <= mem_wdata[7:0];
            end else begin
              state_reg <= READ;
            end
`ifdef MEM_CTRL_RR_EN
            last_if_reg <= 1'b0;
`endif
          end else if (grant_if) begin
            base_reg     <= if_addr;
            len_reg      <= 3'd4;
            sext_reg     <= 1'b0;
            owner_if_reg <= 1'b1;
            ram_addr     <= if_addr;
            state_reg    <= READ;
`ifdef MEM_CTRL_RR_EN
            last_if_reg  <= 1'b1;
`endif
          end
        end
        READ: begin
          // Abort drops the fetch immediately; otherwise leave after the
          // done cycle.
          if ((owner_if_reg && if_abort) || (step_reg == len_reg + 3'd2)) begin
            state_reg <= IDLE;
          end else begin
            step_reg <= step_reg + 3'd1;
            if (step_reg < len_reg)
              ram_addr <= base_reg + {29'd0, step_reg};
            if (step_reg >= 3'd2)
              buf_reg <= buf_next;
            if (step_reg == len_reg + 3'd1) begin
              if (owner_if_reg) begin
                if_done <= 1'b1;
                if_data <= buf_next;
              end else begin
                mem_done  <= 1'b1;
                mem_rdata <= ld_result;
              end
            end
          end
        end
        WRITE: begin
          if (step_reg == len_reg + 3'd1) begin
            state_reg <= IDLE;
          end else if (step_reg == len_reg) begin
            ram_wr   <= 1'b0;
            mem_done <= 1'b1;
            step_reg <= step_reg + 3'd1;
          end else begin
            ram_addr <= base_reg + {29'd0, step_reg};
            ram_dout <= wdata_reg[{step_reg[1:0], 3'b000} +: 8];
            step_reg <= step_reg + 3'd1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: self-checking bench for mem_ctrl. A byte RAM model answers the
// DUT's RAM port; a separate reference memory plus arithmetic byte assembly
// and extension predicts every load/fetch result, latency and store byte.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_abort;
  logic        if_done;
  logic [31:0] if_data;
  logic [2:0]  mem_read;
  logic [1:0]  mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_done;
  logic [31:0] mem_rdata;
  logic        stall_req;
  logic [31:0] ram_addr;
  logic [7:0]  ram_dout;
  logic        ram_wr;
  logic [7:0]  ram_din = 8'd0;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] ram_mem [logic [31:0]];
  logic [7:0] ref_mem [logic [31:0]];

  mem_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_abort  (if_abort),
    .if_done   (if_done),
    .if_data   (if_data),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_done  (mem_done),
    .mem_rdata (mem_rdata),
    .stall_req (stall_req),
    .ram_addr  (ram_addr),
    .ram_dout  (ram_dout),
    .ram_wr    (ram_wr),
    .ram_din   (ram_din)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] init_byte(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ 8'hA5;
  endfunction

  function automatic logic [7:0] ram_byte(input logic [31:0] a);
    return ram_mem.exists(a) ? ram_mem[a] : init_byte(a);
  endfunction

  function automatic logic [7:0] ref_byte(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_byte(a);
  endfunction

  // RAM model: read data appears the cycle after its address
  always @(posedge clk) begin
    if (ram_wr) ram_mem[ram_addr] = ram_dout;
    ram_din <= ram_byte(ram_addr);
  end

  task automatic set_byte(input logic [31:0] a, input logic [7:0] v);
    ram_mem[a] = v;
    ref_mem[a] = v;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int rd_len(input logic [2:0] code);
    if (code == 3'd1 || code == 3'd4) return 1;
    if (code == 3'd2 || code == 3'd5) return 2;
    return 4;
  endfunction

  function automatic int wr_len(input logic [1:0] code);
    if (code == 2'd1) return 1;
    if (code == 2'd2) return 2;
    return 4;
  endfunction

  // Little-endian assembly, then two's-complement sign extension by arithmetic
  function automatic logic [31:0] ref_value(input logic [31:0] a, input int n, input bit sgn);
    logic [31:0] v;
    v = 32'd0;
    for (int i = 0; i < n; i++)
      v = v + ({24'd0, ref_byte(a + 32'(i))} << (8 * i));
    if (sgn && n < 4 && v[8*n-1])
      v = v - (32'd1 << (8 * n));
    return v;
  endfunction

  // One access from an idle controller: drive, watch each cycle, check result
  task automatic run_access(input bit is_if, input logic [2:0] rd, input logic [1:0] wr,
                            input logic [31:0] addr, input logic [31:0] wd);
    int n;
    bit is_wr;
    bit sgn;
    logic [31:0] exp_val;
    logic [31:0] got_val;
    int exp_lat;
    int k;
    bit done;
    bit stall_ok;
    bit stray;
    is_wr = !is_if && (wr != 2'd0);
    sgn   = 1'b0;
    if (is_if)      n = 4;
    else if (is_wr) n = wr_len(wr);
    else begin
      n   = rd_len(rd);
      sgn = (rd == 3'd1) || (rd == 3'd2);
    end
    exp_val = is_wr ? 32'd0 : ref_value(addr, n, sgn);
    exp_lat = is_wr ? n + 1 : n + 2;
    if (is_if) begin
      if_req  = 1'b1;
      if_addr = addr;
    end else begin
      mem_read  = rd;
      mem_write = wr;
      mem_addr  = addr;
      mem_wdata = wd;
    end
    done = 1'b0; stall_ok = 1'b1; stray = 1'b0; k = 0;
    while (!done && k < 20) begin
      @(posedge clk); #1;
      k++;
      if (k <= n) begin
        check($sformatf("addr_byte%0d", k - 1), ram_addr, addr + 32'(k - 1));
        if (is_wr) begin
          check("wr_strobe", {31'd0, ram_wr}, 32'd1);
          check($sformatf("wr_byte%0d", k - 1), {24'd0, ram_dout}, {24'd0, wd[8*(k-1) +: 8]});
        end
      end
      done = is_if ? if_done : mem_done;
      if (is_if ? mem_done : if_done) stray = 1'b1;
      if (!done && !stall_req) stall_ok = 1'b0;
    end
    got_val = is_if ? if_data : mem_rdata;
    if (!done) begin
      check("timeout", 32'd0, 32'd1);
    end else begin
      check("latency", 32'(k), 32'(exp_lat));
      if (is_wr) check("wr_off_at_done", {31'd0, ram_wr}, 32'd0);
      else       check("rdata", got_val, exp_val);
      check("stall_busy", {31'd0, stall_ok}, 32'd1);
      check("stall_at_done", {31'd0, stall_req}, 32'd0);
    end
    check("stray_done", {31'd0, stray}, 32'd0);
    $display("txn %s rd=%0d wr=%0d addr=%h wdata=%h lat=%0d data=%h exp=%h",
             is_if ? "fetch" : (is_wr ? "store" : "load"), rd, wr, addr, wd, k,
             got_val, exp_val);
    if_req = 1'b0; mem_read = 3'd0; mem_write = 2'd0;
    if (is_wr)
      for (int i = 0; i < n; i++) ref_mem[addr + 32'(i)] = wd[8*i +: 8];
    @(posedge clk); #1;
  endtask

  // IF and LW request together; MEM re-requests in its done cycle to tie again
  task automatic tie_test();
    int mem_left;
    int order;
    int n_ev;
    int k;
    int exp_order;
    bit stall_ok;
    logic [31:0] exp_mem;
    logic [31:0] exp_if;
`ifdef MEM_CTRL_RR_EN
    exp_order = 5;   // MEM, IF, MEM
`else
    exp_order = 6;   // MEM, MEM, IF
`endif
    exp_mem = ref_value(32'h40, 4, 1'b0);
    exp_if  = ref_value(32'h200, 4, 1'b0);
    if_req = 1'b1; if_addr = 32'h200;
    mem_read = 3'd3; mem_addr = 32'h40;
    mem_left = 2; order = 0; n_ev = 0; k = 0; stall_ok = 1'b1;
    while ((mem_left > 0 || if_req) && k < 60) begin
      @(posedge clk); #1;
      k++;
      if (if_req && !if_done && !stall_req) stall_ok = 1'b0;
      if (mem_done) begin
        order = order * 2 + 1; n_ev++;
        check("tie_mem_data", mem_rdata, exp_mem);
        mem_left--;
        if (mem_left == 0) mem_read = 3'd0;
      end
      if (if_done) begin
        order = order * 2; n_ev++;
        check("tie_if_data", if_data, exp_if);
        if_req = 1'b0;
      end
    end
    check("tie_events", 32'(n_ev), 32'd3);
    check("tie_order", 32'(order), 32'(exp_order));
    check("tie_if_stall", {31'd0, stall_ok}, 32'd1);
    $display("txn tie order=%0d events=%0d cycles=%0d", order, n_ev, k);
    if_req = 1'b0; mem_read = 3'd0;
    @(posedge clk); #1;
  endtask

  // Fetch aborted in cycle t+3 while an LW waits; LW then runs normally
  task automatic abort_test();
    int k;
    bit saw_if;
    bit got_mem;
    logic [31:0] exp_mem;
    exp_mem = ref_value(32'h40, 4, 1'b0);
    if_req = 1'b1; if_addr = 32'h300;
    k = 0; saw_if = 1'b0; got_mem = 1'b0;
    while (!got_mem && k < 30) begin
      @(posedge clk); #1;
      k++;
      if (if_done) saw_if = 1'b1;
      if (mem_done) begin
        got_mem = 1'b1;
        check("abort_mem_data", mem_rdata, exp_mem);
      end
      if (k == 5) check("abort_grant_addr", ram_addr, 32'h40);
      if (k == 1) begin mem_read = 3'd3; mem_addr = 32'h40; end
      if (k == 3) begin if_abort = 1'b1; if_req = 1'b0; end
      if (k == 4) if_abort = 1'b0;
    end
    check("abort_mem_latency", 32'(k), 32'd10);
    check("abort_no_if_done", {31'd0, saw_if}, 32'd0);
    $display("txn abort mem_done_at=%0d if_done_seen=%0d", k, saw_if);
    mem_read = 3'd0;
    @(posedge clk); #1;
  endtask

  // Reset lands in the first byte cycle of an SH
  task automatic reset_mid_sh();
    bit saw;
    mem_write = 2'd2; mem_addr = 32'h500; mem_wdata = 32'h1234ABCD;
    @(posedge clk); #1;
    check("sh_wr_on", {31'd0, ram_wr}, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_wr_off", {31'd0, ram_wr}, 32'd0);
    check("rst_no_done", {31'd0, mem_done}, 32'd0);
    check("rst_addr", ram_addr, 32'd0);
    rst = 1'b0; mem_write = 2'd0;
    ref_mem[32'h500] = 8'hCD;   // the one byte strobed before reset took hold
    saw = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      if (mem_done || ram_wr) saw = 1'b1;
    end
    check("rst_quiet", {31'd0, saw}, 32'd0);
    $display("txn reset_mid_sh quiet=%0d", !saw);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    logic [2:0]  rd;
    logic [1:0]  wr;
    int          kind;
    rst = 1'b1; if_req = 1'b1; if_addr = 32'h100; if_abort = 1'b0;
    mem_read = 3'd0; mem_write = 2'd0; mem_addr = 32'd0; mem_wdata = 32'd0;
    set_byte(32'h100, 8'h13); set_byte(32'h101, 8'h05);
    set_byte(32'h102, 8'h10); set_byte(32'h103, 8'h00);
    set_byte(32'h20, 8'h80);  set_byte(32'h21, 8'hFF);

    repeat (2) @(posedge clk);
    #1;
    check("rst_ram_addr", ram_addr, 32'd0);
    check("rst_ram_dout", {24'd0, ram_dout}, 32'd0);
    check("rst_ram_wr", {31'd0, ram_wr}, 32'd0);
    check("rst_if_done", {31'd0, if_done}, 32'd0);
    check("rst_mem_done", {31'd0, mem_done}, 32'd0);
    check("rst_if_data", if_data, 32'd0);
    check("rst_mem_rdata", mem_rdata, 32'd0);
    $display("txn reset held 2 cycles");
    rst = 1'b0;

    // Fetch already requested: starts on the first edge after release
    run_access(1'b1, 3'd0, 2'd0, 32'h100, 32'd0);
    check("fetch_word", if_data, 32'h00100513);

    run_access(1'b0, 3'd1, 2'd0, 32'h20, 32'd0);
    check("lb_value", mem_rdata, 32'hFFFFFF80);
    run_access(1'b0, 3'd5, 2'd0, 32'h20, 32'd0);
    check("lhu_value", mem_rdata, 32'h0000FF80);
    run_access(1'b0, 3'd2, 2'd0, 32'h20, 32'd0);
    check("lh_value", mem_rdata, 32'hFFFFFF80);

    run_access(1'b0, 3'd0, 2'd3, 32'hFFFFFFFE, 32'hDEADBEEF);
    run_access(1'b0, 3'd3, 2'd0, 32'hFFFFFFFE, 32'd0);
    check("sw_readback", mem_rdata, 32'hDEADBEEF);

    // Codes 6/7 are not requests
    mem_read = 3'd6; mem_addr = 32'h20;
    @(posedge clk); #1;
    check("code6_stall", {31'd0, stall_req}, 32'd0);
    mem_read = 3'd7;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("code7_stall", {31'd0, stall_req}, 32'd0);
    check("code7_no_access", {31'd0, mem_done | ram_wr}, 32'd0);
    mem_read = 3'd0;
    $display("txn codes 6/7 ignored");
    @(posedge clk); #1;

    run_access(1'b1, 3'd0, 2'd0, 32'h104, 32'd0);   // IF served last
    tie_test();
    abort_test();
    reset_mid_sh();

    for (int i = 0; i < 40; i++) begin
      kind = int'($urandom_range(0, 2));
      if ($urandom_range(0, 3) == 0) a = 32'hFFFFFFFC + 32'($urandom_range(0, 7));
      else                           a = 32'h1000 + 32'($urandom_range(0, 15));
      if (kind == 0) begin
        run_access(1'b1, 3'd0, 2'd0, a, 32'd0);
      end else if (kind == 1) begin
        rd = 3'($urandom_range(1, 5));
        run_access(1'b0, rd, 2'd0, a, 32'd0);
      end else begin
        wr = 2'($urandom_range(1, 3));
        rd = 3'($urandom_range(0, 7));
        run_access(1'b0, rd, wr, a, $urandom);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
